// File: rtl/fixed_adder_tree_pipelined.sv
// Pipelined binary adder tree: IN_SIZE fixed-point operands reduced to one exact sum,
// one register stage per reduction layer, valid/ready with a combinational ready chain.

module fixed_adder_tree_layer #(
    parameter int S      = 8,
    parameter int W      = 16,
    parameter int OW     = W + 1,
    parameter int SIGNED = 1
) (
    input  logic [W-1:0]  din  [S],
    output logic [OW-1:0] dout [(S+1)/2]
);
    function automatic logic [OW-1:0] ext(input logic [W-1:0] x);
        if (SIGNED != 0) return OW'($signed(x));
        else             return OW'(x);
    endfunction

    // Outer elements pair inward: i with S-1-i.
    for (genvar i = 0; i < S/2; i++) begin : g_pair
        assign dout[i] = ext(din[i]) + ext(din[S-1-i]);
    end

    if (S % 2 == 1) begin : g_mid
        assign dout[S/2] = ext(din[S/2]);
    end
endmodule

module fixed_adder_tree_pipelined #(
    parameter int IN_SIZE   = 8,
    parameter int IN_WIDTH  = 16,
    parameter int SIGNED    = 1,
    parameter int OUT_WIDTH = IN_WIDTH + $clog2(IN_SIZE)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [IN_WIDTH-1:0]  data_in [IN_SIZE],
    input  logic                 data_in_valid,
    output logic                 data_in_ready,
    output logic [OUT_WIDTH-1:0] data_out,
    output logic                 data_out_valid,
    input  logic                 data_out_ready
);
    localparam int DEPTH = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1;

    logic [DEPTH:0] rdy;

    for (genvar k = 0; k < DEPTH; k++) begin : stg
        localparam int SK = (IN_SIZE + (1 << k) - 1) >> k;
        localparam int SO = (SK + 1) / 2;
        localparam int WK = IN_WIDTH + k;
        // Last stage is sized to OUT_WIDTH so IN_SIZE=1 collapses to a plain extension.
        localparam int OK = (k == DEPTH-1) ? OUT_WIDTH : WK + 1;

        logic [WK-1:0] din [SK];
        logic [OK-1:0] sum [SO];
        logic [OK-1:0] q   [SO];
        logic          v;
        logic          vsrc;

        if (k == 0) begin : g_src
            assign din  = data_in;
            assign vsrc = data_in_valid;
        end else begin : g_src
            assign din  = stg[k-1].q;
            assign vsrc = stg[k-1].v;
        end

        fixed_adder_tree_layer #(
            .S(SK), .W(WK), .OW(OK), .SIGNED(SIGNED)
        ) u_layer (
            .din  (din),
            .dout (sum)
        );

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v <= 1'b0;
                for (int i = 0; i < SO; i++) q[i] <= '0;
            end else if (rdy[k]) begin
                v <= vsrc;
                q <= sum;
            end
        end
    end

    // An empty stage always accepts, so bubbles compress under a stall.
    for (genvar k = 0; k < DEPTH; k++) begin : g_rdy
        assign rdy[k] = !stg[k].v || rdy[k+1];
    end
    assign rdy[DEPTH] = data_out_ready;

    assign data_in_ready  = rdy[0];
    assign data_out       = stg[DEPTH-1].q[0];
    assign data_out_valid = stg[DEPTH-1].v;
endmodule

// File: tb/tb_fixed_adder_tree_pipelined.sv
// Directed bench: four tree configurations sharing clock/reset, hand-computed sums.

module tb_fixed_adder_tree_pipelined;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // IN_SIZE=8 signed
    logic [15:0] d8 [8];
    logic        v8, r8, ov8, or8;
    logic [18:0] o8;
    // IN_SIZE=8 unsigned
    logic [15:0] du [8];
    logic        vu, ru, ovu, oru;
    logic [18:0] ou;
    // IN_SIZE=5 signed
    logic [15:0] d5 [5];
    logic        v5, r5, ov5, or5;
    logic [18:0] o5;
    // IN_SIZE=1 signed
    logic [15:0] d1 [1];
    logic        v1, r1, ov1, or1;
    logic [15:0] o1;

    fixed_adder_tree_pipelined #(.IN_SIZE(8), .IN_WIDTH(16), .SIGNED(1)) dut8 (
        .clk(clk), .rst_n(rst_n), .data_in(d8), .data_in_valid(v8), .data_in_ready(r8),
        .data_out(o8), .data_out_valid(ov8), .data_out_ready(or8));
    fixed_adder_tree_pipelined #(.IN_SIZE(8), .IN_WIDTH(16), .SIGNED(0)) dutu (
        .clk(clk), .rst_n(rst_n), .data_in(du), .data_in_valid(vu), .data_in_ready(ru),
        .data_out(ou), .data_out_valid(ovu), .data_out_ready(oru));
    fixed_adder_tree_pipelined #(.IN_SIZE(5), .IN_WIDTH(16), .SIGNED(1)) dut5 (
        .clk(clk), .rst_n(rst_n), .data_in(d5), .data_in_valid(v5), .data_in_ready(r5),
        .data_out(o5), .data_out_valid(ov5), .data_out_ready(or5));
    fixed_adder_tree_pipelined #(.IN_SIZE(1), .IN_WIDTH(16), .SIGNED(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .data_in(d1), .data_in_valid(v1), .data_in_ready(r1),
        .data_out(o1), .data_out_valid(ov1), .data_out_ready(or1));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set8(input logic [15:0] val);
        for (int i = 0; i < 8; i++) d8[i] = val;
    endtask

    initial begin
        int sent, recv, acc, nval;
        logic stalled, saw_full;
        logic [18:0] held;

        v8 = 0; vu = 0; v5 = 0; v1 = 0;
        or8 = 1; oru = 1; or5 = 1; or1 = 1;
        set8(16'h0);
        for (int i = 0; i < 8; i++) du[i] = 16'h0;
        for (int i = 0; i < 5; i++) d5[i] = 16'h0;
        d1[0] = 16'h0;

        // reset state
        #2;
        check("rst_ovalid", {31'b0, ov8}, 32'd0);
        check("rst_dout", {13'b0, o8}, 32'd0);
        check("rst_irdy", {31'b0, r8}, 32'd1);
        @(negedge clk);
        rst_n = 1;

        // single vector 1..8 -> 36, valid exactly on the 3rd edge, one cycle wide
        @(negedge clk);
        for (int i = 0; i < 8; i++) d8[i] = 16'(i + 1);
        v8 = 1;
        for (int n = 1; n <= 4; n++) begin
            @(negedge clk);
            v8 = 0;
            #1;
            check($sformatf("lat8_v%0d", n), {31'b0, ov8}, {31'b0, n == 3});
            if (n == 3) check("sum_1to8", {13'b0, o8}, 32'd36);
        end

        // signed and unsigned extremes
        @(negedge clk);
        set8(16'h8000);
        for (int i = 0; i < 8; i++) du[i] = 16'h8000;
        v8 = 1; vu = 1;
        repeat (3) begin @(negedge clk); v8 = 0; vu = 0; end
        #1;
        check("s_8000", {13'b0, o8}, 32'h40000);
        check("u_8000", {13'b0, ou}, 32'h40000);
        for (int i = 0; i < 8; i++) du[i] = 16'hFFFF;
        vu = 1;
        repeat (3) begin @(negedge clk); vu = 0; end
        #1;
        check("u_ffff_v", {31'b0, ovu}, 32'd1);
        check("u_ffff", {13'b0, ou}, 32'd524280);

        // odd size: {-3,7,-1,2,10} -> 15
        @(negedge clk);
        d5[0] = 16'hFFFD; d5[1] = 16'd7; d5[2] = 16'hFFFF; d5[3] = 16'd2; d5[4] = 16'd10;
        v5 = 1;
        for (int n = 1; n <= 3; n++) begin
            @(negedge clk);
            v5 = 0;
            #1;
            check($sformatf("lat5_v%0d", n), {31'b0, ov5}, {31'b0, n == 3});
        end
        check("sum5", {13'b0, o5}, 32'd15);

        // single operand: pure sign extension, latency 1
        @(negedge clk);
        d1[0] = 16'hFFFF; v1 = 1;
        @(negedge clk);
        v1 = 0;
        #1;
        check("one_v", {31'b0, ov1}, 32'd1);
        check("one_d", {16'b0, o1}, 32'h0000FFFF);
        @(negedge clk);
        #1;
        check("one_v_off", {31'b0, ov1}, 32'd0);

        // backpressure: 10 vectors, sink stalled on cycles 4..9
        sent = 0; recv = 0; stalled = 0; saw_full = 0; held = '0;
        for (int c = 0; c < 80 && recv < 10; c++) begin
            @(negedge clk);
            or8 = !(c >= 4 && c <= 9);
            if (sent < 10) begin v8 = 1; set8(16'(sent)); end
            else v8 = 0;
            #1;
            if (!r8) saw_full = 1;
            if (ov8 && stalled) check("bp_stable", {13'b0, o8}, {13'b0, held});
            if (ov8 && or8) begin
                check("bp_data", {13'b0, o8}, 32'(8 * recv));
                recv++;
            end
            stalled = ov8 && !or8;
            held = o8;
            if (v8 && r8) sent++;
        end
        check("bp_count", 32'(recv), 32'd10);
        check("bp_full_seen", {31'b0, saw_full}, 32'd1);
        @(negedge clk);
        v8 = 0; or8 = 1;
        repeat (4) @(negedge clk);
        #1;
        check("bp_no_dup", {31'b0, ov8}, 32'd0);

        // bubbles under stall: ready holds until three valid vectors are resident
        acc = 0;
        @(negedge clk);
        or8 = 0;
        for (int c = 0; c < 8; c++) begin
            if (c > 0) @(negedge clk);
            v8 = (c % 2 == 0) && (acc < 3);
            set8(16'(100 + acc));
            #1;
            check($sformatf("bub_rdy%0d", c), {31'b0, r8}, {31'b0, acc < 3});
            if (v8 && r8) acc++;
        end
        @(negedge clk);
        v8 = 0; or8 = 1;
        recv = 0;
        for (int c = 0; c < 10 && recv < 3; c++) begin
            #1;
            if (ov8) begin
                check("bub_data", {13'b0, o8}, 32'(8 * (100 + recv)));
                recv++;
            end
            @(negedge clk);
        end
        check("bub_count", 32'(recv), 32'd3);

        // asynchronous reset with three vectors in flight
        repeat (2) @(negedge clk);
        for (int k = 1; k <= 3; k++) begin
            set8(16'(k)); v8 = 1;
            @(negedge clk);
        end
        v8 = 0;
        @(posedge clk);
        #2;
        check("pre_rst_v", {31'b0, ov8}, 32'd1);
        rst_n = 0;
        #1;
        check("mid_rst_v", {31'b0, ov8}, 32'd0);
        check("mid_rst_d", {13'b0, o8}, 32'd0);
        check("mid_rst_rdy", {31'b0, r8}, 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1;
        nval = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            #1;
            if (ov8) nval++;
        end
        check("no_stale", 32'(nval), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fixed_adder_tree_pipelined.md
Name: fixed_adder_tree_pipelined

Overview:
- Reduces IN_SIZE fixed-point operands to one full-precision sum.
- Uses a binary tree with one register stage per reduction layer.
- Carries a valid/ready handshake with full-throughput backpressure.
- Sits between parallel multiplier outputs and the accumulator/cast stage of linear and conv datapaths; the successor to the purely combinational single-layer adder.

Parameters:
- IN_SIZE, 8: number of input operands (>=1).
- IN_WIDTH, 16: bit width of each operand.
- SIGNED, 1: 1 = two's-complement sign extension at every layer; 0 = zero extension.
- OUT_WIDTH, IN_WIDTH+$clog2(IN_SIZE): derived; sum width. Do not override.

Ports:
- clk, input, 1: clock, rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- data_in, input, [IN_WIDTH-1:0] x IN_SIZE (unpacked): operands.
- data_in_valid, input, 1: operands valid.
- data_in_ready, output, 1: block accepts operands this cycle.
- data_out, output, OUT_WIDTH: exact sum of the accepted operand vector.
- data_out_valid, output, 1: data_out valid.
- data_out_ready, input, 1: downstream accepts data_out.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Stage count: DEPTH = max(1, $clog2(IN_SIZE)).
- Layer k (k = 0..DEPTH-1):
  - Input: S_k operands (S_0 = IN_SIZE) of width IN_WIDTH+k.
  - Output: ceil(S_k/2) operands of width IN_WIDTH+k+1, registered.
  - Pairing: element i is added to element S_k-1-i.
  - Odd S_k: the middle element passes through, extended by one bit.
  - Extension: sign extension if SIGNED=1, else zero extension.
  - IN_SIZE=1: one register stage, pure extension to OUT_WIDTH.
- Arithmetic is exact (no overflow, no truncation). The final register holds a single element of width OUT_WIDTH.
- Each stage has a valid bit v_k.
  - Stage k is ready when r_k = !v_k || r_{k+1}, with r_DEPTH = data_out_ready.
  - data_in_ready = r_0.
  - Stage k loads when r_k is high. Loaded valid = previous-stage valid (data_in_valid for k=0). Loaded data = combinational layer output.
  - When r_k is low, the stage holds data and valid.
- Ready chain is combinational back to data_in_ready. No skid buffers.
- Throughput: one vector per cycle while data_out_ready=1.
- Latency: DEPTH cycles from accepting handshake to data_out_valid.
- data_out and data_out_valid are driven directly from the last stage register.
  - While data_out_valid && !data_out_ready, data_out must stay stable.
  - No handshake-accepted vector may be dropped or duplicated.
- Bubbles (data_in_valid=0) propagate as invalid stages and are compressible: an invalid stage accepts new data even when downstream is stalled.
- Data registers may load while their valid is 0. Data is don't-care when valid=0, but is reset to 0.
- Reset: on rst_n low, all v_k=0 and all data registers = 0, immediately (async), regardless of in-flight data.
  - Outputs during and after reset: data_out_valid=0, data_out=0.
  - data_in_ready=1 (all stages empty).
- Reset deassertion: first accept possible on the first rising edge with rst_n high.
- Simultaneous events: when the last stage is full and data_out_ready=1, it accepts the new value from stage DEPTH-1 on the same edge that the output is consumed.
- data_in_valid=1 with data_in_ready=0: nothing loads, and the source must hold its data.

Test Plan:
- Single vector, IN_SIZE=8, IN_WIDTH=16, SIGNED=1, inputs 1..8, data_out_ready=1 -> data_out=36 (19-bit), data_out_valid exactly 3 cycles after accept, high for one cycle.
- Signed extremes: all eight inputs 16'h8000 -> data_out=-262144 (19'h40000). With SIGNED=0, same inputs -> 262144 (19'h40000), all 16'hFFFF -> 524280.
- Odd size, IN_SIZE=5, SIGNED=1, inputs {-3,7,-1,2,10} -> data_out=15, latency 3, width 19.
- Backpressure: stream 10 vectors (sum = 8*n for vector n); hold data_out_ready low for cycles 4-9 -> data_in_ready falls once all 3 stages are full. Outputs appear in order 0,8,16,...,72 with no loss or duplication, and data_out is stable while stalled.
- Bubbles: data_in_valid toggling 1,0,1,0 with data_out_ready low -> bubbles are compressed, and data_in_ready stays high until 3 valid vectors are held.
- Reset mid-flight: assert rst_n low asynchronously (between clock edges) with 3 vectors in flight -> data_out_valid=0, data_out=0, data_in_ready=1 immediately. No stale vector emerges after release.
- IN_SIZE=1, input 16'hFFFF, SIGNED=1 -> data_out=16'hFFFF sign-extended to OUT_WIDTH=16 (value -1), latency 1.
